uart_rx_ip: RTL
===============

Name: uart_rx_ip

Overview:
- Memory-mapped UART receiver peripheral: the receive-side counterpart of the SoC's UART transmitter.
- Deserialises 8N1 frames from the RXD pin into a small RX FIFO.
- Exposes data, status and control registers to the CPU over the SoC IO bus, using the same i_sel/i_we/i_addr/i_wdata/o_rdata scheme as the GPIO and PWM IPs.
- Sits in its own IO block, decoded by the SoC.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, must be >= 4).
- FIFO_DEPTH, 4, RX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- i_sel  in  1  block select from SoC address decode.
- i_we  in  1  write strobe; a write occurs when i_sel & i_we.
- i_re  in  1  read strobe; a read occurs when i_sel & i_re.
- i_addr  in  4  byte offset within block.
- i_wdata  in  32  write data.
- o_rdata  out  32  registered read data.
- rxd  in  1  asynchronous serial input; idle high.
- o_irq  out  1  level: FIFO non-empty & CTRL.irq_en.

Behaviour:
- Reset and clock: resetn is synchronous, active-low; clock is clk. Reset values: o_rdata=0, o_irq=0, FIFO empty, overrun=0, ferr=0, CTRL.en=1, CTRL.irq_en=0, RX FSM=IDLE, synchroniser flops=1.
- Register map:
  - 0x0 DATA (read only): {23'b0, valid, byte}. Reading pops one FIFO entry when non-empty. When empty it returns 0 and does not pop.
  - 0x4 STATUS (read): bit0 not_empty, bit1 full, bit2 overrun, bit3 ferr, bits[8:4] fill count. Write-1-to-clear on bits 2 and 3; other bits ignore writes.
  - 0x8 CTRL (R/W): bit0 en, bit1 irq_en.
  - Other offsets read 0; writes to them are ignored.
- Read timing: o_rdata is loaded on the clock edge where i_sel & i_re, from the addressed register's pre-edge value. It holds until the next read, giving 1-cycle latency as for the RAM. Any pop occurs on that same edge.
- Input synchronisation: rxd passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP. There is one baud counter (0..DIV-1) and a 3-bit bit index.
  - IDLE: if en and rx_s==0 -> START, counter cleared.
  - START: at counter == DIV/2-1, if rx_s==0 -> DATA (counter cleared, index=0). Otherwise it was a false start -> IDLE.
  - DATA: each time the counter reaches DIV-1, sample rx_s into shift[index], LSB first. After index 7 -> STOP.
  - STOP: at counter DIV-1, sample. If 1: push byte and go -> IDLE. If 0: set ferr, discard byte, go -> IDLE. IDLE then waits for rx_s to be high before any new start can be detected, so a break line does not retrigger.
- Sampling point: every sample lands at bit centre (start + DIV/2 + k*DIV).
- FIFO full on push: byte is dropped, overrun is set, FIFO contents are unchanged.
- Simultaneous push and pop: both take effect and the count is unchanged. This also holds when full: the pop frees a slot and the push is accepted with no overrun.
- CTRL.en cleared mid-frame: FSM returns to IDLE next cycle and the partial byte is discarded. FIFO and flags are retained.
- Reset mid-frame or mid-read: everything returns to reset values. The FIFO is emptied.
- Fill count is always 0..FIFO_DEPTH. FIFO pointers wrap modulo FIFO_DEPTH.
- o_irq is registered (one cycle after the state change).

Test Plan:
- Basic receive (CLK_FREQ_HZ=16, BAUD_RATE=1, DIV=16): drive frame 0xA5 on rxd -> STATUS reads 0x011; DATA read returns 0x1A5; following STATUS reads 0x000.
- FIFO fill and overrun: send 0x01..0x05 with FIFO_DEPTH=4 and no reads -> STATUS=0x047 (count 4, full, not_empty, overrun). DATA reads yield 0x101, 0x102, 0x103, 0x104, then 0x000. Writing 0x4 to STATUS clears overrun.
- Framing and glitch: send 0x3C with stop bit low -> ferr=1 and FIFO empty. A 3-cycle low glitch on idle rxd -> no byte and no ferr.
- Push/pop collision: with FIFO full, issue a DATA read on the exact edge a stop bit completes -> count stays 4, overrun stays 0, the new byte is last in order.
- Control and reset: clear CTRL.en at data bit 3 -> no byte is pushed. Set en=1, irq_en=1 and receive 0x55 -> o_irq rises. Assert resetn=0 during the next frame -> o_irq=0, FIFO empty, CTRL reads 0x1.
- Read latency: o_rdata changes only on the edge after i_sel & i_re, and holds its value during non-read cycles and writes.

Source files
------------

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with RX FIFO, W1C error flags and level IRQ.
module uart_rx_ip #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        rxd,
  output logic        o_irq
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q, mem_q [FIFO_DEPTH];
  logic armed_q;
  logic [1:0] sync_q, sync_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic ovr_q, ovr_d, ferr_q, ferr_d, en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, reg_val;
  logic rx_s, rd, st_wr, ctl_wr, not_empty, full, push, ferr_set, pop, accept;
  logic unused_wdata;
  assign unused_wdata = ^i_wdata[31:4];
  assign rx_s = sync_q[1];
  assign rd = i_sel & i_re;
  assign st_wr = i_sel & i_we & (i_addr == 4'h4);
  assign ctl_wr = i_sel & i_we & (i_addr == 4'h8);
  assign not_empty = count_q != '0;
  assign full = count_q == NW'(FIFO_DEPTH);
  assign push = en_q && state_q == STOP && cnt_q == LAST && rx_s;
  assign ferr_set = en_q && state_q == STOP && cnt_q == LAST && !rx_s;
  assign reg_val = i_addr == 4'h0 ? (not_empty ? {23'b0, 1'b1, mem_q[rd_ptr_q]} : 32'b0) :
                   i_addr == 4'h4 ? {23'b0, 5'(count_q), ferr_q, ovr_q, full, not_empty} :
                   i_addr == 4'h8 ? {30'b0, irq_en_q, en_q} : 32'b0;
  assign o_rdata = rdata_q;
  assign o_irq = irq_q;
  always_comb begin
    sync_d = {sync_q[0], rxd};
    pop = rd && i_addr == 4'h0 && not_empty;
    accept = push && (!full || pop);
    count_d = count_q + NW'(accept) - NW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovr_d = (ovr_q & ~(st_wr & i_wdata[2])) | (push & full & ~pop);
    ferr_d = (ferr_q & ~(st_wr & i_wdata[3])) | ferr_set;
    en_d = ctl_wr ? i_wdata[0] : en_q;
    irq_en_d = ctl_wr ? i_wdata[1] : irq_en_q;
    irq_d = not_empty & irq_en_q;
    rdata_d = rd ? reg_val : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      en_q <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      sync_q <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      en_q <= en_d;
      irq_en_q <= irq_en_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
    if (accept) mem_q[wr_ptr_q] <= shift_q;
  end
  // armed_q blocks a new start until the line has been seen idle after a framing error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
    end else if (!en_q) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          armed_q <= armed_q | rx_s;
          if (armed_q && !rx_s) begin
            state_q <= START;
            cnt_q <= '0;
          end
        end
        START: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == HALF) begin
            state_q <= rx_s ? IDLE : DATA;
            cnt_q <= '0;
            idx_q <= '0;
          end
        end
        DATA: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            shift_q[idx_q] <= rx_s;
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            armed_q <= rx_s;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
